// File: rtl/potential_decay_scheduler_pkg.sv
// Shared types and constants for the membrane-potential decay sweep scheduler.
package potential_decay_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_DEC,
        ST_WR,
        ST_DONE
    } state_t;

    typedef logic [31:0] potential_t;

    localparam logic [2:0] DECAY_DIV1   = 3'd0;
    localparam logic [2:0] DECAY_DIV2   = 3'd1;
    localparam logic [2:0] DECAY_DIV4   = 3'd2;
    localparam logic [2:0] DECAY_DIV8   = 3'd3;
    localparam logic [2:0] DECAY_DIV2P4 = 3'd4;

    // Magnitude test ignores the sign bit so that -0.0 also counts as zero.
    function automatic logic is_zero_mag(input potential_t p);
        return (p[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/potential_decay_scheduler_lat_counter.sv
// Down-counter that times the hold window of the external decay unit.
module decay_lat_counter #(
    parameter int LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_last
);

    localparam logic [2:0] LOAD_VAL = 3'(LAT - 1);

    logic [2:0] r_cnt;

    // Loaded one cycle before the window, so it holds the cycles remaining after the current one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= 3'd0;
        else if (i_load)
            r_cnt <= LOAD_VAL;
        else if (i_en && r_cnt != 3'd0)
            r_cnt <= r_cnt - 3'd1;
    end

    assign o_last = i_en && (r_cnt == 3'd0);

endmodule

// File: rtl/potential_decay_scheduler.sv
// Sweeps every membrane-potential word through the external decay unit once per timestep tick.
// Optional build macro DECAY_ZERO_SKIP_EN: zero-magnitude words bypass the decay and write-back.
module potential_decay_scheduler
    import potential_decay_scheduler_pkg::*;
#(
    parameter int NUM_NEURONS = 64,
    parameter int ADDR_W      = 6,
    parameter int DECAY_LAT   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              timestep_tick,
    input  logic [2:0]        decay_rate_cfg,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic [31:0]       dec_potential,
    output logic [2:0]        dec_rate,
    input  logic [31:0]       dec_result
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_rate;
    potential_t        r_pot;
    potential_t        r_res;
    logic              r_pending;
    logic              r_overrun;
    logic              w_last;
    logic              w_at_last;
    logic              w_skip;
    logic              w_restart;

    assign w_at_last = (r_addr == LAST_ADDR);
    assign w_restart = r_pending || timestep_tick;

`ifdef DECAY_ZERO_SKIP_EN
    assign w_skip = is_zero_mag(mem_rd_data);
`else
    assign w_skip = 1'b0;
`endif

    decay_lat_counter #(.LAT(DECAY_LAT)) u_lat (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_load (r_state == ST_WAIT),
        .i_en   (r_state == ST_DEC),
        .o_last (w_last)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (timestep_tick) w_next = ST_RD;
            ST_RD:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_skip)
                    w_next = w_at_last ? ST_DONE : ST_RD;
                else
                    w_next = ST_DEC;
            end
            ST_DEC:  if (w_last) w_next = ST_WR;
            ST_WR:   w_next = w_at_last ? ST_DONE : ST_RD;
            ST_DONE: w_next = w_restart ? ST_RD : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr <= '0;
            r_rate <= 3'd0;
            r_pot  <= '0;
            r_res  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (timestep_tick) begin
                    r_rate <= decay_rate_cfg;
                    r_addr <= '0;
                end
                ST_WAIT: begin
                    r_pot <= mem_rd_data;
                    if (w_skip && !w_at_last)
                        r_addr <= r_addr + 1'b1;
                end
                ST_DEC:  if (w_last) r_res <= dec_result;
                ST_WR:   if (!w_at_last) r_addr <= r_addr + 1'b1;
                ST_DONE: if (w_restart) begin
                    r_rate <= decay_rate_cfg;
                    r_addr <= '0;
                end
                default: ;
            endcase
        end
    end

    // In DONE the pending tick is consumed; a coincident tick takes its place only if one was already waiting.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_pending <= r_pending && timestep_tick;
        end else if (r_state != ST_IDLE && timestep_tick) begin
            if (r_pending)
                r_overrun <= 1'b1;
            else
                r_pending <= 1'b1;
        end
    end

    always_comb begin
        busy          = (r_state != ST_IDLE);
        done          = (r_state == ST_DONE);
        overrun       = r_overrun;
        mem_rd_en     = (r_state == ST_RD);
        mem_wr_en     = (r_state == ST_WR);
        mem_addr      = r_addr;
        mem_wr_data   = (r_state == ST_WR)  ? r_res  : 32'd0;
        dec_potential = (r_state == ST_DEC) ? r_pot  : 32'd0;
        dec_rate      = (r_state == ST_DEC) ? r_rate : 3'd0;
    end

endmodule

// File: tb/tb_potential_decay_scheduler.sv
// Directed bench: two schedulers (decay latency 1 and 3) with behavioural memories and decay units.
module tb_potential_decay_scheduler;

    logic        clk;
    logic        rst;
    logic        tick0, tick3;
    logic [2:0]  cfg;

    logic        busy0, done0, ovr0, rd0, wr0;
    logic [5:0]  addr0;
    logic [31:0] rdd0, wrd0, dpot0, dres0;
    logic [2:0]  drate0;

    logic        busy3, done3, ovr3, rd3, wr3;
    logic [5:0]  addr3;
    logic [31:0] rdd3, wrd3, dpot3, dres3;
    logic [2:0]  drate3;

    logic [31:0] mem0 [64];
    logic [31:0] mem3 [64];
    logic [31:0] p1, p2;
    logic        pre0, pre3;
    logic [31:0] pre_val;
    int          both_hi;
    int          errors, checks;

    potential_decay_scheduler u0 (
        .CLK(clk), .RESET(rst), .timestep_tick(tick0), .decay_rate_cfg(cfg),
        .busy(busy0), .done(done0), .overrun(ovr0), .mem_rd_en(rd0), .mem_addr(addr0),
        .mem_rd_data(rdd0), .mem_wr_en(wr0), .mem_wr_data(wrd0),
        .dec_potential(dpot0), .dec_rate(drate0), .dec_result(dres0)
    );

    potential_decay_scheduler #(.DECAY_LAT(3)) u3 (
        .CLK(clk), .RESET(rst), .timestep_tick(tick3), .decay_rate_cfg(cfg),
        .busy(busy3), .done(done3), .overrun(ovr3), .mem_rd_en(rd3), .mem_addr(addr3),
        .mem_rd_data(rdd3), .mem_wr_en(wr3), .mem_wr_data(wrd3),
        .dec_potential(dpot3), .dec_rate(drate3), .dec_result(dres3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural float decay: exponent shifts for /2^k, 0.75x for code 4, identity otherwise.
    function automatic logic [31:0] decay_model(input logic [31:0] x, input logic [2:0] c);
        logic [7:0]  e;
        logic [25:0] s3;
        e = x[30:23];
        if (e < 8'd4) return x;
        case (c)
            3'd1: return {x[31], e - 8'd1, x[22:0]};
            3'd2: return {x[31], e - 8'd2, x[22:0]};
            3'd3: return {x[31], e - 8'd3, x[22:0]};
            3'd4: begin
                s3 = 26'({1'b1, x[22:0]}) * 26'd3;
                if (s3[25]) return {x[31], e, s3[24:2]};
                else        return {x[31], e - 8'd1, s3[23:1]};
            end
            default: return x;
        endcase
    endfunction

    assign dres0 = decay_model(dpot0, drate0);
    assign dres3 = p2;

    always @(posedge clk) begin
        p1 <= decay_model(dpot3, drate3);
        p2 <= p1;
    end

    always @(posedge clk) begin
        if (pre0) for (int i = 0; i < 64; i++) mem0[i] <= pre_val;
        if (rd0) rdd0 <= mem0[addr0];
        if (wr0) mem0[addr0] <= wrd0;
    end

    always @(posedge clk) begin
        if (pre3) for (int i = 0; i < 64; i++) mem3[i] <= pre_val;
        if (rd3) rdd3 <= mem3[addr3];
        if (wr3) mem3[addr3] <= wrd3;
    end

    always @(posedge clk)
        if ((rd0 && wr0) || (rd3 && wr3)) both_hi++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] v, input bit which3);
        pre_val = v;
        if (which3) pre3 = 1'b1; else pre0 = 1'b1;
        step();
        pre0 = 1'b0;
        pre3 = 1'b0;
    endtask

    // Leaves the bench #1 after the edge that moves IDLE to RD (sweep cycle 0).
    task automatic pulse(input bit which3);
        if (which3) tick3 = 1'b1; else tick0 = 1'b1;
        step();
        tick0 = 1'b0;
        tick3 = 1'b0;
    endtask

    task automatic wait_done(input bit which3, output int cyc);
        cyc = 0;
        while (!(which3 ? done3 : done0) && cyc < 2000) begin
            step();
            cyc++;
        end
    endtask

    function automatic int count_bad(input bit which3, input int lo, input int hi,
                                     input logic [31:0] exp);
        int bad;
        bad = 0;
        for (int i = lo; i <= hi; i++)
            if ((which3 ? mem3[i] : mem0[i]) !== exp) bad++;
        return bad;
    endfunction

    typedef struct {
        logic [2:0]  rate;
        logic [31:0] init;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc;
        errors = 0; checks = 0; both_hi = 0;
        tick0 = 0; tick3 = 0; cfg = 3'd0; pre0 = 0; pre3 = 0; pre_val = '0;
        vecs[0] = '{3'd1, 32'h41000000, 32'h40800000};
        vecs[1] = '{3'd0, 32'h41000000, 32'h41000000};
        vecs[2] = '{3'd2, 32'h41000000, 32'h40000000};
        vecs[3] = '{3'd3, 32'h41000000, 32'h3F800000};
        vecs[4] = '{3'd4, 32'h41000000, 32'h40C00000};
        vecs[5] = '{3'd5, 32'h41000000, 32'h41000000};
        vecs[6] = '{3'd1, 32'hC1000000, 32'hC0800000};
        vecs[7] = '{3'd4, 32'h40400000, 32'h40100000};

        rst = 1'b1;
        #1;
        check("reset flags", {27'd0, busy0, done0, ovr0, rd0, wr0}, 32'd0);
        check("reset dec_potential", dpot0, 32'd0);
        check("reset addr/rate", {23'd0, addr0, drate0}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            preload(vecs[v].init, 1'b0);
            cfg = vecs[v].rate;
            pulse(1'b0);
            wait_done(1'b0, cyc);
            check($sformatf("vec%0d sweep length", v), 32'(cyc), 32'd256);
            step();
            check($sformatf("vec%0d busy after done", v), {31'd0, busy0}, 32'd0);
            check($sformatf("vec%0d bad words", v), 32'(count_bad(1'b0, 0, 63, vecs[v].exp)), 32'd0);
        end

        // Rate change mid-sweep must not affect the sweep in flight.
        preload(32'h41000000, 1'b0);
        cfg = 3'd1;
        pulse(1'b0);
        repeat (5) step();
        cfg = 3'd3;
        wait_done(1'b0, cyc);
        check("rate change length", 32'(cyc), 32'd251);
        step();
        check("rate change words", 32'(count_bad(1'b0, 0, 63, 32'h40800000)), 32'd0);

        // Pending tick at cycle 10, lost tick at cycle 20.
        preload(32'h41000000, 1'b0);
        cfg = 3'd1;
        pulse(1'b0);
        repeat (10) step();
        pulse(1'b0);
        check("pending no overrun", {31'd0, ovr0}, 32'd0);
        repeat (9) step();
        pulse(1'b0);
        check("overrun set", {31'd0, ovr0}, 32'd1);
        wait_done(1'b0, cyc);
        check("first sweep remainder", 32'(cyc), 32'd235);
        step();
        check("second sweep starts", {30'd0, busy0, rd0}, 32'd3);
        check("second sweep addr", {26'd0, addr0}, 32'd0);
        wait_done(1'b0, cyc);
        check("second sweep length", 32'(cyc), 32'd256);
        step();
        check("idle after second", {31'd0, busy0}, 32'd0);
        check("overrun sticky", {31'd0, ovr0}, 32'd1);
        check("two sweeps words", 32'(count_bad(1'b0, 0, 63, 32'h40000000)), 32'd0);

        // Reset at cycle 50 aborts while neuron 12 is in flight.
        preload(32'h41000000, 1'b0);
        cfg = 3'd1;
        pulse(1'b0);
        repeat (50) step();
        rst = 1'b1;
        #1;
        check("abort flags", {27'd0, busy0, done0, ovr0, rd0, wr0}, 32'd0);
        check("abort outputs", {wrd0 | dpot0}, 32'd0);
        check("abort addr", {26'd0, addr0}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check("abort decayed 0..11", 32'(count_bad(1'b0, 0, 11, 32'h40800000)), 32'd0);
        check("abort untouched 12..63", 32'(count_bad(1'b0, 12, 63, 32'h41000000)), 32'd0);
        check("abort stays idle", {31'd0, busy0}, 32'd0);

        // Decay latency 3, code 4 on 8.0.
        preload(32'h41000000, 1'b1);
        cfg = 3'd4;
        pulse(1'b1);
        wait_done(1'b1, cyc);
        check("lat3 sweep length", 32'(cyc), 32'd384);
        step();
        check("lat3 busy after done", {31'd0, busy3}, 32'd0);
        check("lat3 words", 32'(count_bad(1'b1, 0, 63, 32'h40C00000)), 32'd0);

        check("rd/wr overlap cycles", 32'(both_hi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
